fp_reduce_minmax: RTL and testbench

Streaming floating-point min/max reduction unit for the FPU datapath. It accepts a vector of IEEE-754-format operands, one element per cycle over a valid/ready handshake, and returns one result per vector:

- the extreme value (maximum or minimum, selected per vector);
- the index of that element;
- the element count;
- a NaN-seen flag.

It generalises the two-operand combinational comparator into a parametrised, sequential arg-max/arg-min engine with correct signed-zero and NaN handling.

---
 rtl/fp_reduce_minmax.sv | 78 +++++++
 tb/tb_fp_reduce_minmax.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fp_reduce_minmax.sv
// fp_reduce_minmax: streaming IEEE-754 arg-max/arg-min reduction with signed-zero and NaN handling
module fp_reduce_minmax #(
  parameter int DATA_WIDTH = 32,
  parameter int EXPO_WIDTH = 8,
  parameter int MANT_WIDTH = 23,
  parameter int IDX_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [IDX_WIDTH-1:0]  out_index_o,
  output logic [IDX_WIDTH-1:0]  out_count_o,
  output logic                  out_nan_o
);
  typedef enum logic [1:0] {FIRST, ACCUM, HOLD} state_t;
  localparam logic [DATA_WIDTH-1:0] QNAN = {1'b0, {EXPO_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] acc, e_val;
  logic [DATA_WIDTH-2:0] e_mag, a_mag;
  logic [IDX_WIDTH-1:0] idx, cnt;
  logic mode_q, nan_q, in_fire, e_s, a_s, e_nan, a_nan, gt, lt, take;
  assign in_ready_o  = state != HOLD;
  assign out_valid_o = state == HOLD;
  assign out_data_o  = acc;
  assign out_index_o = idx;
  assign out_count_o = cnt;
  assign out_nan_o   = nan_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign {e_s, e_mag} = in_data_i;
  assign {a_s, a_mag} = acc;
  assign e_nan = (&in_data_i[DATA_WIDTH-2:MANT_WIDTH]) & (|in_data_i[MANT_WIDTH-1:0]);
  assign a_nan = (&acc[DATA_WIDTH-2:MANT_WIDTH]) & (|acc[MANT_WIDTH-1:0]);
  // NaNs are stored canonicalised so an all-NaN vector yields the quiet NaN directly
  assign e_val = e_nan ? QNAN : in_data_i;
  always_comb begin
    gt = (e_s != a_s) ? !e_s : (e_s ? e_mag < a_mag : e_mag > a_mag);
    lt = (e_s != a_s) ? e_s : (e_s ? e_mag > a_mag : e_mag < a_mag);
    take = !e_nan & (a_nan | (mode_q ? lt : gt));
  end
  always_comb begin
    state_n = state;
    if (state == HOLD) state_n = out_ready_i ? FIRST : HOLD;
    else if (in_fire) state_n = in_last_i ? HOLD : ACCUM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FIRST;
      acc    <= '0;
      idx    <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
      nan_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (in_fire && state == FIRST) begin
        acc    <= e_val;
        idx    <= '0;
        cnt    <= IDX_WIDTH'(1);
        mode_q <= mode_i;
        nan_q  <= e_nan;
      end else if (in_fire) begin
        cnt   <= cnt + 1'b1;
        nan_q <= nan_q | e_nan;
        if (take) begin
          acc <= e_val;
          idx <= cnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_fp_reduce_minmax.sv
// tb_fp_reduce_minmax: directed and randomized checks against an ordering-key reference model
module tb_fp_reduce_minmax;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic mode = 0, iv = 0, il = 0, ordy = 0, ir, ov, onan;
  logic [31:0] id = 0, od;
  logic [15:0] oi, oc;
  logic m2 = 0, v2 = 0, l2 = 0, r2 = 0, ir2, ov2, on2;
  logic [31:0] d2 = 0, od2;
  logic [1:0] oi2, oc2;
  int n_cmp = 0, n_err = 0;
  logic [31:0] vec [64];
  int vlen;

  fp_reduce_minmax u1 (.clk(clk), .rst(rst), .mode_i(mode), .in_valid_i(iv), .in_ready_o(ir),
    .in_data_i(id), .in_last_i(il), .out_valid_o(ov), .out_ready_i(ordy), .out_data_o(od),
    .out_index_o(oi), .out_count_o(oc), .out_nan_o(onan));
  fp_reduce_minmax #(.IDX_WIDTH(2)) u2 (.clk(clk), .rst(rst), .mode_i(m2), .in_valid_i(v2),
    .in_ready_o(ir2), .in_data_i(d2), .in_last_i(l2), .out_valid_o(ov2), .out_ready_i(r2),
    .out_data_o(od2), .out_index_o(oi2), .out_count_o(oc2), .out_nan_o(on2));

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction

  // Signed integer key whose natural order is the required float order (+0 > -0)
  function automatic longint fkey(input logic [31:0] x);
    return x[31] ? -longint'(x[30:0]) - 1 : longint'(x[30:0]);
  endfunction

  function automatic void model(input logic m, input int iw, output logic [31:0] d,
                                output int ix, output int c, output logic nn);
    int best = -1;
    nn = 0;
    for (int i = 0; i < vlen; i++)
      if (is_nan(vec[i])) nn = 1;
      else if (best < 0 || (m ? fkey(vec[i]) < fkey(vec[best]) : fkey(vec[i]) > fkey(vec[best])))
        best = i;
    d = best < 0 ? 32'h7FC00000 : vec[best];
    ix = best < 0 ? 0 : best % (1 << iw);
    c = vlen % (1 << iw);
  endfunction

  task automatic send(input logic m);
    for (int i = 0; i < vlen; i++) begin
      @(negedge clk);
      iv = 1; id = vec[i]; il = (i == vlen - 1);
      mode = (i == 0) ? m : 1'($urandom);
      for (int t = 0; t < 10 && !ir; t++) @(negedge clk);
      chk("in_ready", 64'(ir), 1);
      @(posedge clk);
    end
    @(negedge clk);
    iv = 0; il = 0;
    chk("latency", 64'(ov), 1);
  endtask

  task automatic expect_res(input logic m, input string tag);
    logic [31:0] d; int ix, c; logic nn;
    model(m, 16, d, ix, c, nn);
    chk({tag, ".data"}, 64'(od), 64'(d));
    chk({tag, ".index"}, 64'(oi), 64'(ix));
    chk({tag, ".count"}, 64'(oc), 64'(c));
    chk({tag, ".nan"}, 64'(onan), 64'(nn));
  endtask

  task automatic drain(input int delay);
    logic [64:0] held;
    held = {od, oi, oc, onan};
    repeat (delay) begin
      chk("bp.in_ready", 64'(ir), 0);
      chk("bp.valid", 64'(ov), 1);
      chk("bp.stable", 64'({od, oi, oc, onan} == held), 1);
      @(negedge clk);
    end
    ordy = 1;
    @(negedge clk);
    ordy = 0;
    chk("drain.valid", 64'(ov), 0);
    chk("drain.in_ready", 64'(ir), 1);
  endtask

  task automatic run(input logic m, input string tag, input int delay);
    send(m);
    expect_res(m, tag);
    drain(delay);
  endtask

  initial begin
    logic [31:0] x; logic m; int k;
    logic [31:0] ed; int eix, ec; logic en;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst.valid", 64'(ov), 0);
    chk("rst.outs", 64'({od, oi, oc, onan}), 0);
    chk("rst.in_ready", 64'(ir), 1);
    vlen = 4; vec[0] = 32'h3F800000; vec[1] = 32'hC0000000; vec[2] = 32'h40600000; vec[3] = 32'h3F800000;
    run(0, "max", 0);
    vlen = 3; vec[0] = 32'h00000000; vec[1] = 32'h80000000; vec[2] = 32'h80000000;
    run(1, "min_tie", 0);
    vlen = 3; vec[0] = 32'h7FC00001; vec[1] = 32'hBF800000; vec[2] = 32'h7F800001;
    run(0, "nan", 0);
    vlen = 1; vec[0] = 32'hFFC00000;
    run(0, "allnan", 5);
    vlen = 1; vec[0] = 32'hFF800000;
    run(1, "neginf", 0);
    // abandon a partial vector with reset
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); iv = 1; id = 32'h7F800000; il = 0; mode = 0;
      @(posedge clk);
    end
    @(negedge clk); iv = 0; rst = 1;
    @(negedge clk); rst = 0;
    chk("rstmid.valid", 64'(ov), 0);
    chk("rstmid.outs", 64'({od, oi, oc, onan}), 0);
    vlen = 1; vec[0] = 32'h40000000;
    run(0, "after_rst", 0);
    // latched mode: later mode_i values are random inside send
    vlen = 6; vec[0] = 32'h3F800000; vec[1] = 32'h40000000; vec[2] = 32'hBF800000;
    vec[3] = 32'h40400000; vec[4] = 32'hC0400000; vec[5] = 32'h00000000;
    run(0, "latch_max", 0);
    run(1, "latch_min", 0);
    for (int r = 0; r < 40; r++) begin
      vlen = $urandom_range(1, 9);
      for (int i = 0; i < vlen; i++) begin
        k = $urandom_range(0, 9);
        x = $urandom;
        if (x[30:23] == 8'hFF) x[30] = 0;
        case (k)
          0: x = 32'h00000000;
          1: x = 32'h80000000;
          2: x = 32'h7F800000;
          3: x = 32'hFF800000;
          4: x = {x[31], 8'hFF, x[22:0] | 23'h1};
          5: if (i > 0) x = vec[i-1];
          default: ;
        endcase
        vec[i] = x;
      end
      m = 1'($urandom);
      run(m, "rand", $urandom_range(0, 3));
    end
    // narrow index counter wraps
    vlen = 5; vec[0] = 32'h40000000; vec[1] = 32'h40400000; vec[2] = 32'h40800000;
    vec[3] = 32'h40A00000; vec[4] = 32'h40C00000;
    for (int i = 0; i < vlen; i++) begin
      @(negedge clk); v2 = 1; d2 = vec[i]; l2 = (i == vlen - 1); m2 = (i == 0) ? 1'b0 : 1'b1;
      chk("wrap.in_ready", 64'(ir2), 1);
      @(posedge clk);
    end
    @(negedge clk); v2 = 0; l2 = 0;
    model(0, 2, ed, eix, ec, en);
    chk("wrap.valid", 64'(ov2), 1);
    chk("wrap.data", 64'(od2), 64'(ed));
    chk("wrap.index", 64'(oi2), 64'(eix));
    chk("wrap.count", 64'(oc2), 64'(ec));
    chk("wrap.nan", 64'(on2), 64'(en));
    r2 = 1; @(negedge clk); r2 = 0;
    chk("wrap.drain", 64'(ov2), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
